// File: rtl/fsm_c_pkg.sv
// Shared definitions for the fsm_c_param transaction-layer control FSM:
// one-hot state encoding, state index names and small helper functions.
package fsm_c_pkg;

    // Bit position of each state inside the one-hot state register.
    typedef enum int {
        IDX_RESET  = 0,
        IDX_INIT   = 1,
        IDX_IDLE   = 2,
        IDX_ACTIVE = 3,
        IDX_ERROR  = 4
    } state_idx_e;

    localparam int NUM_STATES = 5;

    localparam logic [NUM_STATES-1:0] OH_RESET  = NUM_STATES'(1) << IDX_RESET;
    localparam logic [NUM_STATES-1:0] OH_INIT   = NUM_STATES'(1) << IDX_INIT;
    localparam logic [NUM_STATES-1:0] OH_IDLE   = NUM_STATES'(1) << IDX_IDLE;
    localparam logic [NUM_STATES-1:0] OH_ACTIVE = NUM_STATES'(1) << IDX_ACTIVE;
    localparam logic [NUM_STATES-1:0] OH_ERROR  = NUM_STATES'(1) << IDX_ERROR;

    typedef enum logic [NUM_STATES-1:0] {
        ST_RESET  = OH_RESET,
        ST_INIT   = OH_INIT,
        ST_IDLE   = OH_IDLE,
        ST_ACTIVE = OH_ACTIVE,
        ST_ERROR  = OH_ERROR
    } state_t;

    // Upper bounds the helpers accept; callers zero-extend narrower buses.
    localparam int MAX_CH    = 64;
    localparam int MAX_UMB_W = 32;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic int lowest_set_index(input logic [MAX_CH-1:0] mask);
        int idx;
        idx = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // True when the low threshold of a {high, low} pair exceeds the high one.
    function automatic logic pair_invalid(input logic [2*MAX_UMB_W-1:0] bus,
                                          input int                     umb_w);
        logic [MAX_UMB_W-1:0] lo;
        logic [MAX_UMB_W-1:0] hi;
        lo = '0;
        hi = '0;
        for (int i = 0; i < MAX_UMB_W; i++) begin
            if (i < umb_w) begin
                lo[i] = bus[i];
                hi[i] = bus[i + umb_w];
            end
        end
        return lo > hi;
    endfunction

endpackage

// File: rtl/fsm_c_idle_timer.sv
// Saturating idle counter: counts enabled cycles, clears on request, and
// flags the cycle on which the LIMIT-th consecutive enabled cycle occurs.
// LIMIT = 0 disables the terminal flag entirely.
module fsm_c_idle_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] SAT_V  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CNT_W-1:0] count;

    // Count enabled cycles, holding at LIMIT so the counter never wraps.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != SAT_V)) begin
            count <= count + 1'b1;
        end
    end

    // Terminal when this enabled cycle would be the LIMIT-th in a row.
    always_comb begin
        done = (LIMIT > 0) && enable && !clear && (count == LAST_V);
    end

endmodule

// File: rtl/fsm_c_param.sv
// Parametrised transaction-layer control FSM. Captures and validates the
// UMF/UVC/UD threshold pairs, supervises NUM_CH FIFOs, returns to IDLE after
// a run of all-empty ACTIVE cycles and records which FIFOs raised errors.
module fsm_c_param
    import fsm_c_pkg::*;
#(
    parameter int NUM_CH       = 5,
    parameter int UMB_W        = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 err_clear,
    input  logic [2*UMB_W-1:0]   UMF,
    input  logic [2*UMB_W-1:0]   UVC,
    input  logic [2*UMB_W-1:0]   UD,
    input  logic [NUM_CH-1:0]    FIFO_ERROR,
    input  logic [NUM_CH-1:0]    FIFO_EMPTY,
    output logic                 idle_out_c,
    output logic                 active_out_c,
    output logic                 error_out_c,
    output logic                 cfg_err,
    output logic [2*UMB_W-1:0]   UMF_OUT_c,
    output logic [2*UMB_W-1:0]   UVC_OUT_c,
    output logic [2*UMB_W-1:0]   UD_OUT_c,
    output logic [NUM_CH-1:0]    err_ch,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] err_first
);
    localparam int ERR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BUS_W = 2 * MAX_UMB_W;

    state_t     state;
    logic       any_data;
    logic       any_err;
    logic       cfg_bad;
    logic       timer_clr;
    logic       timer_en;
    logic       timer_done;
    logic [ERR_W-1:0] first_idx;

    // Input summaries and the validity check of the presented configuration.
    always_comb begin
        any_data  = |(~FIFO_EMPTY);
        any_err   = |FIFO_ERROR;
        cfg_bad   = pair_invalid(BUS_W'(UMF), UMB_W)
                  | pair_invalid(BUS_W'(UVC), UMB_W)
                  | pair_invalid(BUS_W'(UD),  UMB_W);
        first_idx = ERR_W'(lowest_set_index(MAX_CH'(FIFO_ERROR)));
        timer_en  = (state == ST_ACTIVE) && !any_data;
        timer_clr = (state != ST_ACTIVE) || any_data;
    end

    fsm_c_idle_timer #(
        .LIMIT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .done   (timer_done)
    );

    // Status flags decode straight from the one-hot state register.
    always_comb begin
        idle_out_c   = (state == ST_IDLE);
        active_out_c = (state == ST_ACTIVE);
        error_out_c  = (state == ST_ERROR);
    end

    // Main controller: state transitions, config capture and error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RESET;
            cfg_err   <= 1'b0;
            UMF_OUT_c <= '0;
            UVC_OUT_c <= '0;
            UD_OUT_c  <= '0;
            err_ch    <= '0;
            err_first <= '0;
        end else begin
            unique case (state)
                ST_RESET: begin
                    if (init) begin
                        state     <= ST_INIT;
                        err_ch    <= '0;
                        err_first <= '0;
                    end
                end
                ST_INIT: begin
                    UMF_OUT_c <= UMF;
                    UVC_OUT_c <= UVC;
                    UD_OUT_c  <= UD;
                    cfg_err   <= cfg_bad;
                    state     <= cfg_bad ? ST_ERROR : ST_IDLE;
                end
                ST_IDLE, ST_ACTIVE: begin
                    if (any_err) begin
                        state     <= ST_ERROR;
                        err_ch    <= FIFO_ERROR;
                        err_first <= first_idx;
                    end else if (init) begin
                        state     <= ST_INIT;
                        err_ch    <= '0;
                        err_first <= '0;
                    end else if ((state == ST_IDLE) && any_data) begin
                        state <= ST_ACTIVE;
                    end else if ((state == ST_ACTIVE) && timer_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    if (init) begin
                        state     <= ST_INIT;
                        err_ch    <= '0;
                        err_first <= '0;
                    end else if (err_clear && !any_err && !cfg_err) begin
                        state     <= ST_IDLE;
                        err_ch    <= '0;
                        err_first <= '0;
                    end else begin
                        err_ch <= err_ch | FIFO_ERROR;
                    end
                end
                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_c_param.sv
// Self-checking bench for fsm_c_param: directed walk through the main
// scenarios followed by random traffic, all compared against a behavioural
// model of the controller rules.
module tb_fsm_c_param;
    localparam int NUM_CH       = 5;
    localparam int UMB_W        = 4;
    localparam int IDLE_TIMEOUT = 4;
    localparam int CW           = 2 * UMB_W;
    localparam int EW           = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic              err_clear;
    logic [CW-1:0]     UMF;
    logic [CW-1:0]     UVC;
    logic [CW-1:0]     UD;
    logic [NUM_CH-1:0] FIFO_ERROR;
    logic [NUM_CH-1:0] FIFO_EMPTY;
    logic              idle_out_c;
    logic              active_out_c;
    logic              error_out_c;
    logic              cfg_err;
    logic [CW-1:0]     UMF_OUT_c;
    logic [CW-1:0]     UVC_OUT_c;
    logic [CW-1:0]     UD_OUT_c;
    logic [NUM_CH-1:0] err_ch;
    logic [EW-1:0]     err_first;

    fsm_c_param #(
        .NUM_CH       (NUM_CH),
        .UMB_W        (UMB_W),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .err_clear    (err_clear),
        .UMF          (UMF),
        .UVC          (UVC),
        .UD           (UD),
        .FIFO_ERROR   (FIFO_ERROR),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .idle_out_c   (idle_out_c),
        .active_out_c (active_out_c),
        .error_out_c  (error_out_c),
        .cfg_err      (cfg_err),
        .UMF_OUT_c    (UMF_OUT_c),
        .UVC_OUT_c    (UVC_OUT_c),
        .UD_OUT_c     (UD_OUT_c),
        .err_ch       (err_ch),
        .err_first    (err_first)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: controller mode plus the values it should be showing.
    typedef enum {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mode_e;
    mode_e m_mode = M_RESET;
    int    m_umf = 0, m_uvc = 0, m_ud = 0;
    bit    m_cfg_err = 1'b0;
    int    m_err_ch = 0;
    int    m_err_first = 0;
    int    m_quiet = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_pair(input int v);
        return (v % (1 << UMB_W)) > (v / (1 << UMB_W));
    endfunction

    function automatic int lowest_bit(input int v);
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Apply the controller rules to the inputs about to be sampled.
    task automatic model_step();
        bit data, err, bad;
        data = (FIFO_EMPTY != {NUM_CH{1'b1}});
        err  = (FIFO_ERROR != '0);
        if (reset) begin
            m_mode = M_RESET; m_umf = 0; m_uvc = 0; m_ud = 0;
            m_cfg_err = 0; m_err_ch = 0; m_err_first = 0; m_quiet = 0;
            return;
        end
        case (m_mode)
            M_RESET: if (init) begin m_mode = M_INIT; m_err_ch = 0; m_err_first = 0; end
            M_INIT: begin
                m_umf = int'(UMF); m_uvc = int'(UVC); m_ud = int'(UD);
                bad = bad_pair(m_umf) || bad_pair(m_uvc) || bad_pair(m_ud);
                m_cfg_err = bad;
                m_mode = bad ? M_ERROR : M_IDLE;
            end
            M_IDLE, M_ACTIVE: begin
                if (m_mode == M_ACTIVE) m_quiet = data ? 0 : m_quiet + 1;
                if (err) begin
                    m_mode = M_ERROR;
                    m_err_ch = int'(FIFO_ERROR);
                    m_err_first = lowest_bit(int'(FIFO_ERROR));
                end else if (init) begin
                    m_mode = M_INIT; m_err_ch = 0; m_err_first = 0;
                end else if (m_mode == M_IDLE && data) begin
                    m_mode = M_ACTIVE; m_quiet = 0;
                end else if (m_mode == M_ACTIVE && IDLE_TIMEOUT > 0 && m_quiet >= IDLE_TIMEOUT) begin
                    m_mode = M_IDLE;
                end
            end
            M_ERROR: begin
                if (init) begin
                    m_mode = M_INIT; m_err_ch = 0; m_err_first = 0;
                end else if (err_clear && !err && !m_cfg_err) begin
                    m_mode = M_IDLE; m_err_ch = 0; m_err_first = 0;
                end else begin
                    m_err_ch = m_err_ch | int'(FIFO_ERROR);
                end
            end
            default: m_mode = M_RESET;
        endcase
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".idle"},      32'(idle_out_c),   32'(m_mode == M_IDLE));
        check({ctx, ".active"},    32'(active_out_c), 32'(m_mode == M_ACTIVE));
        check({ctx, ".error"},     32'(error_out_c),  32'(m_mode == M_ERROR));
        check({ctx, ".cfg_err"},   32'(cfg_err),      32'(m_cfg_err));
        check({ctx, ".umf"},       32'(UMF_OUT_c),    32'(m_umf));
        check({ctx, ".uvc"},       32'(UVC_OUT_c),    32'(m_uvc));
        check({ctx, ".ud"},        32'(UD_OUT_c),     32'(m_ud));
        check({ctx, ".err_ch"},    32'(err_ch),       32'(m_err_ch));
        check({ctx, ".err_first"}, 32'(err_first),    32'(m_err_first));
    endtask

    // One clock: update the model, let the edge happen, compare 1 ns later.
    task automatic tick(input string ctx);
        model_step();
        @(posedge clk);
        #1;
        compare_all(ctx);
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; err_clear = 1'b0;
        UMF = '0; UVC = '0; UD = '0;
        FIFO_ERROR = '0; FIFO_EMPTY = '1;

        // Reset and a valid configuration.
        tick("rst0");
        tick("rst1");
        reset = 1'b0;
        tick("hold_reset");
        UMF = 8'h52; UVC = 8'h31; UD = 8'h60; init = 1'b1;
        tick("enter_init");
        init = 1'b0;
        tick("cfg_ok");
        check("cfg_ok.idle_const", 32'(idle_out_c), 32'd1);
        check("cfg_ok.umf_const",  32'(UMF_OUT_c),  32'h52);
        check("cfg_ok.uvc_const",  32'(UVC_OUT_c),  32'h31);
        check("cfg_ok.ud_const",   32'(UD_OUT_c),   32'h60);

        // Invalid configuration, ignored err_clear, then a corrected one.
        UVC = 8'h39; init = 1'b1;
        tick("bad_init");
        init = 1'b0;
        tick("bad_cfg");
        check("bad_cfg.cfg_err_const", 32'(cfg_err),     32'd1);
        check("bad_cfg.error_const",   32'(error_out_c), 32'd1);
        err_clear = 1'b1;
        tick("bad_cfg_clear");
        check("bad_cfg_clear.error_const", 32'(error_out_c), 32'd1);
        err_clear = 1'b0; UVC = 8'h93; init = 1'b1;
        tick("fix_init");
        init = 1'b0;
        tick("fix_cfg");
        check("fix_cfg.cfg_err_const", 32'(cfg_err), 32'd0);

        // Activity and idle timeout.
        FIFO_EMPTY = 5'b11011;
        tick("go_active");
        FIFO_EMPTY = '1;
        for (int i = 0; i < 3; i++) tick("quiet_a");
        check("quiet_a.active_const", 32'(active_out_c), 32'd1);
        FIFO_EMPTY = 5'b11110;
        tick("busy");
        FIFO_EMPTY = '1;
        for (int i = 0; i < 3; i++) tick("quiet_b");
        check("quiet_b.active_const", 32'(active_out_c), 32'd1);
        tick("timeout");
        check("timeout.idle_const", 32'(idle_out_c), 32'd1);

        // Error capture from ACTIVE.
        FIFO_EMPTY = 5'b11011;
        tick("go_active2");
        FIFO_EMPTY = '1; FIFO_ERROR = 5'b10100;
        tick("err_entry");
        FIFO_ERROR = 5'b00001;
        tick("err_accum");
        check("err_accum.first_const", 32'(err_first), 32'd2);
        check("err_accum.ch_const",    32'(err_ch),    32'h15);

        // Recovery without reset.
        err_clear = 1'b1;
        tick("clear_blocked");
        check("clear_blocked.error_const", 32'(error_out_c), 32'd1);
        FIFO_ERROR = '0;
        tick("clear_ok");
        check("clear_ok.idle_const", 32'(idle_out_c), 32'd1);
        check("clear_ok.ch_const",   32'(err_ch),     32'd0);
        check("clear_ok.uvc_const",  32'(UVC_OUT_c),  32'h93);
        err_clear = 1'b0;

        // Reset mid-ACTIVE dominates simultaneous init and err_clear.
        FIFO_EMPTY = 5'b11011;
        tick("go_active3");
        FIFO_EMPTY = '1;
        for (int i = 0; i < 3; i++) tick("quiet_c");
        reset = 1'b1; init = 1'b1; err_clear = 1'b1;
        tick("mid_reset");
        check("mid_reset.umf_const",  32'(UMF_OUT_c),  32'd0);
        check("mid_reset.idle_const", 32'(idle_out_c), 32'd0);
        reset = 1'b0; init = 1'b0; err_clear = 1'b0;
        tick("after_reset");

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            init       = ($urandom_range(0, 15) == 0);
            err_clear  = ($urandom_range(0, 3) == 0);
            FIFO_ERROR = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom) : '0;
            FIFO_EMPTY = ($urandom_range(0, 2) == 0) ? NUM_CH'($urandom) : '1;
            UMF        = CW'($urandom);
            UVC        = CW'($urandom);
            UD         = CW'($urandom);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
